cpu_step_ctrl: RTL and testbench

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/tb_ctrl_pkg.sv | 30 +++
 rtl/bp_match.sv | 38 +++
 rtl/cpu_step_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pkg
// Shared encodings for the CPU step controller: the 2-bit debug mode requested
// by the front panel and the controller FSM states. Imported by cpu_step_ctrl.
// -----------------------------------------------------------------------------
package tb_ctrl_pkg;

  // Debug mode as driven on the mode input.
  typedef enum logic [1:0] {
    MODE_RUN        = 2'b00,
    MODE_PHASE_STEP = 2'b01,
    MODE_INSTR_STEP = 2'b10,
    MODE_HALT       = 2'b11
  } mode_e;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP_PH = 3'd2,
    ST_STEP_IN = 3'd3,
    ST_BREAK   = 3'd4
  } state_e;

  // True for the states that are allowed to hand cpuCe through to the core.
  function automatic logic is_active(state_e s);
    return (s == ST_RUN) || (s == ST_STEP_PH) || (s == ST_STEP_IN);
  endfunction

endpackage

// File: rtl/bp_match.sv
// -----------------------------------------------------------------------------
// bp_match
// Breakpoint comparator array. Each enabled slot compares its address with
// the current pc; when several slots match, the lowest slot index is reported.
//
// Ports:
//   pc      in  PC_W         current core program counter
//   bp_addr in  NUM_BP*PC_W  slot i at bits [i*PC_W +: PC_W]
//   bp_en   in  NUM_BP       per-slot enable
//   hit     out 1            at least one enabled slot matches
//   idx     out IDX_W        lowest matching slot (0 when no hit)
// -----------------------------------------------------------------------------
module bp_match #(
  parameter int PC_W   = 12,
  parameter int NUM_BP = 2,
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  // Scan from the highest slot down so the lowest matching slot is the last
  // one written and therefore wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
// Run / single-step / breakpoint controller for a micro-phased CPU core. It
// gates the clock controller's cpuCe tick into coreCe, tracks the micro-phase
// within the current instruction and counts retired instructions.
//
// Ports:
//   clk      in  1            system clock, rising edge
//   rst      in  1            synchronous active-high reset
//   cpuCe    in  1            one-clk tick from the clock controller
//   mode     in  2            00 RUN, 01 PHASE_STEP, 10 INSTR_STEP, 11 HALT
//   stepReq  in  1            one-clk step request
//   resume   in  1            one-clk pulse leaving BREAK
//   pc       in  PC_W         current core program counter
//   bpAddr   in  NUM_BP*PC_W  breakpoint addresses
//   bpEn     in  NUM_BP       breakpoint enables
//   coreCe   out 1            gated enable to pc/rom/alu/register blocks
//   cycle    out CYC_W        current micro-phase
//   sync     out 1            last phase of the instruction
//   halted   out 1            controller is in STOP or BREAK
//   bpHit    out 1            controller is in BREAK
//   bpIdx    out IDX_W        slot that caused the last break
//   instrCnt out CNT_W        retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module cpu_step_ctrl
  import tb_ctrl_pkg::*;
#(
  parameter int PHASES = 8,
  parameter int PC_W   = 12,
  parameter int NUM_BP = 2,
  parameter int CNT_W  = 16,
  localparam int CYC_W = (PHASES > 1) ? $clog2(PHASES) : 1,
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpuCe,
  input  logic [1:0]             mode,
  input  logic                   stepReq,
  input  logic                   resume,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bpAddr,
  input  logic [NUM_BP-1:0]      bpEn,
  output logic                   coreCe,
  output logic [CYC_W-1:0]       cycle,
  output logic                   sync,
  output logic                   halted,
  output logic                   bpHit,
  output logic [IDX_W-1:0]       bpIdx,
  output logic [CNT_W-1:0]       instrCnt
);

  localparam logic [CYC_W-1:0] LAST_PHASE = CYC_W'(PHASES - 1);

  state_e           state;
  state_e           state_next;
  mode_e            mode_cur;
  logic             skip_bp;
  logic             match_hit;
  logic [IDX_W-1:0] match_idx;
  logic             break_now;
  logic             core_en;
  logic             take_break;

  assign mode_cur = mode_e'(mode);
  assign sync     = (cycle == LAST_PHASE);

  bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc      (pc),
    .bp_addr (bpAddr),
    .bp_en   (bpEn),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  // Breakpoints only fire at an instruction boundary while running freely.
  // skip_bp lets the instruction we just broke on execute after a resume.
  assign break_now = (state == ST_RUN) && (cycle == '0) && !skip_bp && match_hit;

  // Next-state and core enable. The enable is built per state so that the
  // two cases that must swallow a tick (breakpoint hit, PHASE_STEP selected
  // while running) simply never raise it.
  always_comb begin
    state_next = state;
    core_en    = 1'b0;
    take_break = 1'b0;
    case (state)
      ST_STOP: begin
        if (mode_cur == MODE_RUN) begin
          state_next = ST_RUN;
        end else if (stepReq) begin
          if (mode_cur == MODE_PHASE_STEP) begin
            state_next = ST_STEP_PH;
          end else if (mode_cur == MODE_INSTR_STEP) begin
            state_next = ST_STEP_IN;
          end
        end
      end
      ST_RUN: begin
        if (mode_cur == MODE_PHASE_STEP) begin
          state_next = ST_STOP;
        end else if (cpuCe && break_now) begin
          take_break = 1'b1;
          state_next = ST_BREAK;
        end else begin
          core_en = cpuCe;
          // Any other non-RUN mode lets the current instruction finish.
          if ((mode_cur != MODE_RUN) && cpuCe && sync) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STEP_PH: begin
        core_en = cpuCe;
        if (cpuCe) begin
          state_next = ST_STOP;
        end
      end
      ST_STEP_IN: begin
        core_en = cpuCe;
        if (cpuCe && sync) begin
          state_next = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (resume) begin
          state_next = (mode_cur == MODE_RUN) ? ST_RUN : ST_STOP;
        end
      end
      default: begin
        state_next = ST_STOP;
      end
    endcase
  end

  // Reset overrides the outputs combinationally so nothing leaks to the core
  // in the clock where reset is first seen.
  assign coreCe = core_en && is_active(state) && !rst;
  assign halted = rst || (state == ST_STOP) || (state == ST_BREAK);
  assign bpHit  = !rst && (state == ST_BREAK);

  // State register, phase/instruction counters and breakpoint bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_STOP;
      cycle    <= '0;
      instrCnt <= '0;
      skip_bp  <= 1'b0;
      bpIdx    <= '0;
    end else begin
      state <= state_next;
      if (core_en) begin
        cycle <= sync ? '0 : cycle + 1'b1;
        if (sync) begin
          instrCnt <= instrCnt + 1'b1;
        end
      end
      if ((state == ST_BREAK) && resume) begin
        skip_bp <= 1'b1;
      end else if (core_en) begin
        skip_bp <= 1'b0;
      end
      if (take_break) begin
        bpIdx <= match_idx;
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_ctrl
// Directed bench for cpu_step_ctrl. Two instances share the stimulus: dut8
// (PHASES=8, CNT_W=4) carries most of the checks, dut5 (PHASES=5) covers the
// five-phase step sequence.
// -----------------------------------------------------------------------------
module tb_cpu_step_ctrl;
  import tb_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpuCe;
  logic [1:0]  mode;
  logic        stepReq;
  logic        resume;
  logic [11:0] pc;
  logic [23:0] bpAddr;
  logic [1:0]  bpEn;

  logic        ce8, sync8, halted8, hit8;
  logic [2:0]  cyc8;
  logic [0:0]  idx8;
  logic [3:0]  cnt8;

  logic        ce5, sync5, halted5, hit5;
  logic [2:0]  cyc5;
  logic [0:0]  idx5;
  logic [15:0] cnt5;

  int vecCount  = 0;
  int missCount = 0;
  int ce5Count  = 0;

  cpu_step_ctrl #(.PHASES(8), .PC_W(12), .NUM_BP(2), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .cpuCe(cpuCe), .mode(mode), .stepReq(stepReq),
    .resume(resume), .pc(pc), .bpAddr(bpAddr), .bpEn(bpEn),
    .coreCe(ce8), .cycle(cyc8), .sync(sync8), .halted(halted8),
    .bpHit(hit8), .bpIdx(idx8), .instrCnt(cnt8)
  );

  cpu_step_ctrl #(.PHASES(5), .PC_W(12), .NUM_BP(2), .CNT_W(16)) dut5 (
    .clk(clk), .rst(rst), .cpuCe(cpuCe), .mode(mode), .stepReq(stepReq),
    .resume(resume), .pc(pc), .bpAddr(bpAddr), .bpEn(bpEn),
    .coreCe(ce5), .cycle(cyc5), .sync(sync5), .halted(halted5),
    .bpHit(hit5), .bpIdx(idx5), .instrCnt(cnt5)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts core enables seen by the five-phase instance.
  always @(posedge clk) begin
    if (ce5) ce5Count <= ce5Count + 1;
  end

  // One row per clock: inputs for that clock, the coreCe expected before the
  // edge, and cycle/halted expected after it.
  typedef struct {
    logic [1:0] vMode;
    logic       vCe;
    logic       vStep;
    logic       vRes;
    logic       expCe;
    int         expCycle;
    logic       expHalted;
  } vec_t;

  vec_t vecs[17];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic ce,
                               input logic st, input logic rs);
    mode    = m;
    cpuCe   = ce;
    stepReq = st;
    resume  = rs;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetDuts();
    rst = 1'b1;
    applyStimulus(MODE_HALT, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Main sequence: reset, five-phase stepping, table, run/wrap/reset,
  // mode changes while running, breakpoints.
  initial begin
    rst    = 1'b1;
    pc     = 12'h000;
    bpAddr = '0;
    bpEn   = 2'b00;
    applyStimulus(MODE_HALT, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();

    checkOutput("rst halted", halted8, 1);
    checkOutput("rst cycle", cyc8, 0);
    checkOutput("rst instrCnt", cnt8, 0);
    checkOutput("rst bpHit", hit8, 0);
    checkOutput("rst bpIdx", idx8, 0);
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("rst coreCe", ce8, 0);
    cyc();
    rst = 1'b0;
    applyStimulus(MODE_HALT, 1'b0, 1'b0, 1'b0);
    cyc();

    // Three phase steps on the five-phase instance.
    begin
      int base;
      base = ce5Count;
      for (int k = 0; k < 3; k++) begin
        applyStimulus(MODE_PHASE_STEP, 1'b0, 1'b1, 1'b0);
        cyc();
        applyStimulus(MODE_PHASE_STEP, 1'b1, 1'b0, 1'b0);
        cyc();
        applyStimulus(MODE_PHASE_STEP, 1'b0, 1'b0, 1'b0);
        cyc();
      end
      checkOutput("p5 coreCe count", ce5Count - base, 3);
    end
    checkOutput("p5 cycle", cyc5, 3);
    checkOutput("p5 halted", halted5, 1);
    checkOutput("p5 instrCnt", cnt5, 0);
    checkOutput("p8 cycle", cyc8, 3);

    // Table: phase stepping, ignored requests, instruction step from cycle 2.
    vecs[0]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[1]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1};
    vecs[2]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    vecs[3]  = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    vecs[4]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    vecs[5]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1};
    vecs[6]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1};
    vecs[8]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0};
    vecs[9]  = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0};
    vecs[10] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0};
    vecs[11] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
    vecs[12] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0};
    vecs[13] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0};
    vecs[14] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 7, 1'b0};
    vecs[15] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    vecs[16] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1};

    resetDuts();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].vMode, vecs[i].vCe, vecs[i].vStep, vecs[i].vRes);
      #2;
      checkOutput($sformatf("vec%0d coreCe", i), ce8, int'(vecs[i].expCe));
      cyc();
      checkOutput($sformatf("vec%0d cycle", i), cyc8, vecs[i].expCycle);
      checkOutput($sformatf("vec%0d halted", i), halted8, int'(vecs[i].expHalted));
    end
    checkOutput("istep instrCnt", cnt8, 1);

    // Free run with cpuCe every 4 clocks, then wrap of the 4-bit counter,
    // then reset mid-instruction.
    resetDuts();
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b0);
    cyc();
    begin
      int expCyc;
      expCyc = 0;
      for (int t = 0; t < 24; t++) begin
        applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput($sformatf("run%0d cycle", t), cyc8, expCyc);
        checkOutput($sformatf("run%0d sync", t), sync8, (expCyc == 7) ? 1 : 0);
        checkOutput($sformatf("run%0d coreCe", t), ce8, 1);
        cyc();
        expCyc = (expCyc + 1) % 8;
        applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        cyc();
      end
    end
    checkOutput("run instrCnt", cnt8, 3);
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0);
    repeat (112) cyc();
    checkOutput("wrap instrCnt", cnt8, 1);
    repeat (4) cyc();
    checkOutput("pre-rst cycle", cyc8, 4);
    rst = 1'b1;
    #2;
    checkOutput("mid rst coreCe", ce8, 0);
    checkOutput("mid rst halted", halted8, 1);
    cyc();
    checkOutput("mid rst cycle", cyc8, 0);
    rst = 1'b0;
    applyStimulus(MODE_HALT, 1'b0, 1'b0, 1'b0);
    cyc();
    checkOutput("post rst halted", halted8, 1);
    checkOutput("post rst instrCnt", cnt8, 0);

    // Leaving RUN mid-instruction: HALT finishes the instruction, PHASE_STEP
    // stops at once.
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc();
    applyStimulus(MODE_HALT, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #2;
      checkOutput($sformatf("finish%0d coreCe", k), ce8, 1);
      cyc();
    end
    checkOutput("finish cycle", cyc8, 0);
    checkOutput("finish halted", halted8, 1);
    #2;
    checkOutput("finish stop coreCe", ce8, 0);
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc();
    applyStimulus(MODE_PHASE_STEP, 1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("phase stop coreCe", ce8, 0);
    cyc();
    checkOutput("phase stop halted", halted8, 1);
    checkOutput("phase stop cycle", cyc8, 2);

    // Breakpoints: both slots at 0x005, lowest slot wins; resume runs the
    // broken-on instruction; then only slot 1 enabled.
    resetDuts();
    bpAddr = {12'h005, 12'h005};
    bpEn   = 2'b11;
    pc     = 12'h004;
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b0);
    cyc();
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc();
    pc = 12'h005;
    #2;
    checkOutput("bp coreCe", ce8, 0);
    cyc();
    checkOutput("bp bpHit", hit8, 1);
    checkOutput("bp bpIdx", idx8, 0);
    checkOutput("bp halted", halted8, 1);
    checkOutput("bp cycle", cyc8, 0);
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b1);
    cyc();
    checkOutput("resume bpHit", hit8, 0);
    checkOutput("resume halted", halted8, 0);
    bpEn = 2'b10;
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("resume coreCe", ce8, 1);
    cyc();
    checkOutput("resume cycle", cyc8, 1);
    repeat (7) cyc();
    #2;
    checkOutput("bp2 coreCe", ce8, 0);
    cyc();
    checkOutput("bp2 bpHit", hit8, 1);
    checkOutput("bp2 bpIdx", idx8, 1);
    applyStimulus(MODE_PHASE_STEP, 1'b0, 1'b1, 1'b1);
    cyc();
    checkOutput("res+step halted", halted8, 1);
    checkOutput("res+step bpHit", hit8, 0);
    applyStimulus(MODE_PHASE_STEP, 1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("res+step coreCe", ce8, 0);
    cyc();
    checkOutput("res+step cycle", cyc8, 0);
    applyStimulus(MODE_HALT, 1'b1, 1'b0, 1'b1);
    cyc();
    checkOutput("stray resume halted", halted8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
